// File: rtl/adc_serial_streamer.sv
// -----------------------------------------------------------------------------
// adc_serial_streamer
//
// Sweeps the ADC channels round-robin. For each channel it waits for the
// matching sample from the AVR interface block and prints that sample on the
// serial TX interface as a fixed 7-byte ASCII line "C:SSS\r\n". C is the
// channel as one hex digit. SSS is the 10-bit sample as three uppercase hex
// digits.
//
// Ports
//   clk             system clock
//   rst             asynchronous reset, active low
//   enable          1 = stream lines; 0 = stop at the next line boundary
//   channel         requested ADC channel (to the AVR interface)
//   new_sample      one-cycle strobe; sample / sample_channel valid with it
//   sample          10-bit ADC result
//   sample_channel  channel that was actually converted
//   tx_data         byte to transmit; held until the next strobe
//   new_tx_data     one-cycle transmit strobe
//   tx_busy         serial transmitter busy
//   sample_drop     one-cycle pulse: new_sample arrived while not waiting
//   timeout_err     one-cycle pulse: a channel produced no sample in time
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module adc_serial_streamer #(
    parameter int NUM_CH  = 8,     // channels swept, 1..16
    parameter int TIMEOUT = 4200   // cycles to wait per channel, >= 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    output logic [3:0] channel,
    input  logic       new_sample,
    input  logic [9:0] sample,
    input  logic [3:0] sample_channel,
    output logic [7:0] tx_data,
    output logic       new_tx_data,
    input  logic       tx_busy,
    output logic       sample_drop,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SAMPLE,
        SEND,
        HOLD
    } state_t;

    localparam int              CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [3:0]       CH_LAST  = 4'(NUM_CH - 1);
    localparam logic [2:0]       LAST_IDX = 3'd6;

    state_t            state;
    logic [CNT_W-1:0]  to_cnt;      // cycles spent waiting on the current channel
    logic [2:0]        byte_idx;    // position inside the 7-byte line
    logic              hold_cnt;    // HOLD lasts exactly two cycles
    logic [9:0]        sample_q;    // captured sample for the line in progress
    logic              tx_busy_q;   // registered copy of the transmitter busy flag

    logic [3:0]        next_ch;
    logic [7:0]        line_byte;
    logic              sample_match;

    // Uppercase ASCII hex digit.
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10)
            return 8'h30 + {4'h0, n};
        else
            return 8'h41 + {4'h0, n} - 8'd10;
    endfunction

    // Round-robin advance. With a single channel this stays at 0.
    assign next_ch      = (channel >= CH_LAST) ? 4'd0 : channel + 4'd1;
    assign sample_match = new_sample && (sample_channel == channel);

    // Byte of the current line selected by byte_idx. The sample is zero
    // extended to 12 bits so it splits into three whole hex digits.
    always_comb begin
        logic [11:0] s_ext;
        // NOTE: every always_comb output gets a default first, so no path
        // can leave it unassigned and infer a latch.
        line_byte = 8'h0A;
        s_ext     = {2'b00, sample_q};
        case (byte_idx)
            3'd0:    line_byte = hex_ascii(channel);
            3'd1:    line_byte = 8'h3A;
            3'd2:    line_byte = hex_ascii(s_ext[11:8]);
            3'd3:    line_byte = hex_ascii(s_ext[7:4]);
            3'd4:    line_byte = hex_ascii(s_ext[3:0]);
            3'd5:    line_byte = 8'h0D;
            default: line_byte = 8'h0A;
        endcase
    end

    // Control FSM with registered outputs. Pulse outputs default low every
    // cycle and are raised for one cycle where needed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            channel     <= 4'd0;
            byte_idx    <= 3'd0;
            to_cnt      <= '0;
            hold_cnt    <= 1'b0;
            // NOTE: the sample latch is reset with the control state. It is a
            // single register, not a memory array, and this keeps tx_data
            // deterministic after reset.
            sample_q    <= 10'd0;
            tx_busy_q   <= 1'b0;
            tx_data     <= 8'h00;
            new_tx_data <= 1'b0;
            sample_drop <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only. All
            // right-hand sides then see pre-edge values, whatever the
            // statement order.
            new_tx_data <= 1'b0;
            sample_drop <= 1'b0;
            timeout_err <= 1'b0;
            tx_busy_q   <= tx_busy;

            case (state)
                IDLE: begin
                    to_cnt <= '0;
                    if (new_sample)
                        sample_drop <= 1'b1;
                    if (enable)
                        state <= WAIT_SAMPLE;
                end

                WAIT_SAMPLE: begin
                    // A matching sample beats both a falling enable and the
                    // timeout. Mismatched samples are stale results of the
                    // previous request and are dropped silently.
                    if (sample_match) begin
                        sample_q <= sample;
                        byte_idx <= 3'd0;
                        to_cnt   <= '0;
                        state    <= SEND;
                    end else if (!enable) begin
                        to_cnt <= '0;
                        state  <= IDLE;
                    end else if (to_cnt == CNT_LAST) begin
                        timeout_err <= 1'b1;
                        channel     <= next_ch;
                        to_cnt      <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                SEND: begin
                    if (new_sample)
                        sample_drop <= 1'b1;
                    if (!tx_busy_q) begin
                        tx_data     <= line_byte;
                        new_tx_data <= 1'b1;
                        hold_cnt    <= 1'b0;
                        state       <= HOLD;
                    end
                end

                HOLD: begin
                    // Two dead cycles after each strobe. They cover the
                    // transmitter's latency in raising tx_busy. Enable is only
                    // looked at once the whole line is out.
                    if (new_sample)
                        sample_drop <= 1'b1;
                    if (!hold_cnt) begin
                        hold_cnt <= 1'b1;
                    end else if (byte_idx == LAST_IDX) begin
                        channel <= next_ch;
                        to_cnt  <= '0;
                        state   <= enable ? WAIT_SAMPLE : IDLE;
                    end else begin
                        byte_idx <= byte_idx + 3'd1;
                        state    <= SEND;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/adc_serial_streamer.md
Name: adc_serial_streamer

Overview:
- Consumes the ADC sample stream produced by the AVR interface block (new_sample / sample / sample_channel).
- Drives its channel-select input so that it sweeps channels round-robin.
- Formats each captured sample as a fixed 7-byte ASCII line, "C:SSS\r\n", and pushes the bytes into the serial TX user interface (tx_data / new_tx_data / tx_busy).
- Gives a continuous text dump of all analog inputs over the AVR USB serial link.

Parameters:
- NUM_CH, 8: number of channels swept, 0..NUM_CH-1; legal range 1..16.
- TIMEOUT, 4200: clk cycles to wait for a matching sample before abandoning the channel; legal range >= 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-low (rst=0 resets). Codebase naming is kept.
- enable  in  1  1 = stream; 0 = stop at the next line boundary.
- channel  out  4  requested ADC channel; connects to the AVR interface channel input.
- new_sample  in  1  one-cycle strobe; sample and sample_channel are valid with it.
- sample  in  10  ADC result.
- sample_channel  in  4  channel that was actually sampled.
- tx_data  out  8  byte to transmit.
- new_tx_data  out  1  one-cycle transmit strobe.
- tx_busy  in  1  serial transmitter busy.
- sample_drop  out  1  one-cycle pulse: a new_sample arrived while not waiting for one.
- timeout_err  out  1  one-cycle pulse: a channel timed out.

Behaviour:
- Reset (async, rst=0):
  - state=IDLE; channel=0; byte index=0; timeout counter=0.
  - tx_data=8'h00; new_tx_data=0; sample_drop=0; timeout_err=0.
  - Outputs are registered; no output is combinational from an input.
- States:
  - IDLE: leaves to WAIT_SAMPLE when enable=1; clears the timeout counter.
  - WAIT_SAMPLE:
    - new_sample=1 with sample_channel==channel: latch sample, byte index=0, go to SEND.
    - new_sample=1 with a mismatched channel: ignore silently. These are stale results from the previous request and are not counted as drops.
    - Counter reaches TIMEOUT-1 with no match: pulse timeout_err, advance channel, clear counter, stay in WAIT_SAMPLE.
    - enable=0: go to IDLE immediately.
  - SEND: when tx_busy=0, drive tx_data = byte[index], pulse new_tx_data for exactly one cycle, go to HOLD.
  - HOLD:
    - Lasts exactly 2 cycles. Covers tx_busy rising latency; tx_busy is ignored during this time.
    - Then: index<6 → index+1, return to SEND.
    - index==6 → advance channel; go to WAIT_SAMPLE if enable=1, else IDLE.
- Line bytes, with S = {2'b00, sample}:
  - byte0: hex digit of channel.
  - byte1: 8'h3A (':').
  - bytes 2-4: hex of S[11:8], S[7:4], S[3:0].
  - byte5: 8'h0D; byte6: 8'h0A.
  - Hex digits are uppercase: 0-9 → 8'h30+n; A-F → 8'h41+(n-10).
- Channel advance: channel+1, wrapping NUM_CH-1 → 0. With NUM_CH=1, channel stays 0.
- new_tx_data is never asserted in a cycle where registered tx_busy was 1. tx_data holds its value until the next strobe.
- sample_drop: pulsed for any new_sample received in IDLE, SEND or HOLD. The sample is discarded and the line in progress is unaffected.
- Simultaneous events in WAIT_SAMPLE:
  - Matching new_sample in the timeout cycle: the sample wins; no timeout_err.
  - Matching new_sample together with enable falling: the sample is captured and its line is sent; then IDLE.
- enable=0 during SEND/HOLD: the full 7-byte line still completes; lines are never truncated.
- Reset mid-line: transmission stops immediately; new_tx_data=0 on the next edge. Partial lines are not resumed.

Test Plan:
- Reset release, enable=1, channel=0; inject sample=10'h2A7 with sample_channel=0; tx_busy pulses high for 10 cycles after each strobe → bytes exactly 30 3A 32 41 37 0D 0A, then channel=1.
- NUM_CH=3; matching samples 10'h000, 10'h3FF, 10'h155 → lines "0:000", "1:3FF", "2:155"; channel sequence 0,1,2,0.
- In WAIT_SAMPLE on channel 2, inject sample_channel=1 → ignored, no sample_drop; then sample_channel=2 → line "2:…" sent.
- No samples for TIMEOUT cycles → timeout_err exactly once at cycle TIMEOUT after entry, channel+1; a matching sample in that same cycle → line sent, no timeout_err.
- new_sample during byte 3 of a line → sample_drop=1 for one cycle; line bytes unchanged.
- enable=0 at byte 2 → line completes, IDLE, no further strobes. Separately, rst=0 asynchronously at byte 4 → new_tx_data=0 and channel=0 immediately.
